// File: rtl/edge_trigger_if.sv
// Edge detector signal bundle: monitored input, enable and the resulting edge flag.
interface edge_trigger_if;
    logic IN;
    logic En;
    logic EDGE;

    // Driver side: supplies the monitored signal and enable, observes the flag.
    modport master (
        output IN,
        output En,
        input  EDGE
    );

    // Detector side.
    modport slave (
        input  IN,
        input  En,
        output EDGE
    );
endinterface

// File: rtl/edge_trigger.sv
// Gated single-signal edge detector with optional input synchroniser.
// The flag is combinational and qualified by En; an edge seen while En is low
// stays pending in the history register until the next enabled cycle.
module edge_trigger #(
    parameter bit          POSEDGE     = 1'b1,
    parameter int unsigned SYNC_STAGES = 0
) (
    input logic           clk,
    input logic           RESET,
    edge_trigger_if.slave bus
);

    // Reset loads the post-edge level, so a level already present at reset
    // release is not reported as an edge (rising: 1, falling: 0).
    localparam logic IDLE = POSEDGE;

    logic w_s;
    logic w_hit;
    logic r_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = bus.IN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Free-running synchroniser chain, independent of En.
            always_ff @(posedge clk or posedge RESET) begin
                if (RESET) begin
                    r_sync <= {SYNC_STAGES{IDLE}};
                end else begin
                    r_sync[0] <= bus.IN;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // History register: follows the sampled input only on enabled cycles.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_prev <= IDLE;
        end else if (bus.En) begin
            r_prev <= w_s;
        end
    end

    generate
        if (POSEDGE) begin : g_rise
            assign w_hit = w_s & ~r_prev;
        end else begin : g_fall
            assign w_hit = ~w_s & r_prev;
        end
    endgenerate

    assign bus.EDGE = ~RESET & bus.En & w_hit;

`ifndef SYNTHESIS
    // The flag must stay low whenever reset is asserted.
    a_no_edge_in_reset: assert property (@(posedge clk) RESET |-> !bus.EDGE);

    // A reported edge updates the history, so the next cycle cannot report again.
    a_single_pulse: assert property (@(posedge clk) disable iff (RESET)
        (bus.En && bus.EDGE) |=> !bus.EDGE);
`endif

endmodule

// File: tb/tb_edge_trigger.sv
// Self-checking bench for edge_trigger: rising/falling detectors without
// synchroniser and a rising detector with a two-stage synchroniser.
module tb_edge_trigger;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    bit   sb[$];

    edge_trigger_if bus_r ();
    edge_trigger_if bus_f ();
    edge_trigger_if bus_s ();

    edge_trigger #(.POSEDGE(1'b1), .SYNC_STAGES(0)) u_rise (
        .clk   (clk),
        .RESET (rst),
        .bus   (bus_r.slave)
    );

    edge_trigger #(.POSEDGE(1'b0), .SYNC_STAGES(0)) u_fall (
        .clk   (clk),
        .RESET (rst),
        .bus   (bus_f.slave)
    );

    edge_trigger #(.POSEDGE(1'b1), .SYNC_STAGES(2)) u_sync (
        .clk   (clk),
        .RESET (rst),
        .bus   (bus_s.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit e;
        rst = 1'b1;
        bus_r.IN = 1'b1; bus_r.En = 1'b1;
        bus_f.IN = 1'b0; bus_f.En = 1'b1;
        bus_s.IN = 1'b1; bus_s.En = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        @(negedge clk);
        e = sb.pop_front(); checks++;
        if (bus_r.EDGE !== e) begin errors++; $display("FAIL reset_rise: EDGE=%b expected %b", bus_r.EDGE, e); end
        e = sb.pop_front(); checks++;
        if (bus_f.EDGE !== e) begin errors++; $display("FAIL reset_fall: EDGE=%b expected %b", bus_f.EDGE, e); end
        e = sb.pop_front(); checks++;
        if (bus_s.EDGE !== e) begin errors++; $display("FAIL reset_sync: EDGE=%b expected %b", bus_s.EDGE, e); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_rise_basic();
        bit in_v[14]  = '{0,0,0,0,0,1,1,1,1,1,0,0,0,0};
        bit exp_v[14] = '{0,0,0,0,0,1,0,0,0,0,0,0,0,0};
        bit e;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            bus_r.En = 1'b1;
            bus_r.IN = in_v[c];
            sb.push_back(exp_v[c]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_r.EDGE !== e) begin errors++; $display("FAIL rise_basic cyc %0d: EDGE=%b expected %b", c, bus_r.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fall();
        bit in_v[12]  = '{1,1,1,1,0,0,0,0,1,1,0,0};
        bit exp_v[12] = '{0,0,0,0,1,0,0,0,0,0,1,0};
        bit e;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus_f.En = 1'b1;
            bus_f.IN = in_v[c];
            sb.push_back(exp_v[c]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_f.EDGE !== e) begin errors++; $display("FAIL fall cyc %0d: EDGE=%b expected %b", c, bus_f.EDGE, e); end
            @(posedge clk);
            #1;
        end
        // Reset with the post-edge level held: nothing reported after release.
        bus_f.IN = 1'b0;
        rst = 1'b1;
        sb.push_back(1'b0);
        #2;
        e = sb.pop_front(); checks++;
        if (bus_f.EDGE !== e) begin errors++; $display("FAIL fall_in_reset: EDGE=%b expected %b", bus_f.EDGE, e); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sb.push_back(1'b0);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_f.EDGE !== e) begin errors++; $display("FAIL fall_after_reset cyc %0d: EDGE=%b expected %b", c, bus_f.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_deferred();
        bit en_v[12]  = '{1,1,1,0,0,0,0,0,0,1,1,1};
        bit in_v[12]  = '{0,0,0,0,1,1,1,1,1,1,1,1};
        bit exp_v[12] = '{0,0,0,0,0,0,0,0,0,1,0,0};
        bit e;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            bus_r.En = en_v[c];
            bus_r.IN = in_v[c];
            sb.push_back(exp_v[c]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_r.EDGE !== e) begin errors++; $display("FAIL deferred cyc %0d: EDGE=%b expected %b", c, bus_r.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_lost_pulse();
        bit en_v[14]  = '{1,1,1,0,0,0,0,0,0,1,1,1,1,1};
        bit in_v[14]  = '{0,0,0,0,0,1,1,0,0,0,0,0,1,1};
        bit exp_v[14] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0};
        bit e;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            bus_r.En = en_v[c];
            bus_r.IN = in_v[c];
            sb.push_back(exp_v[c]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_r.EDGE !== e) begin errors++; $display("FAIL lost_pulse cyc %0d: EDGE=%b expected %b", c, bus_r.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_sync_latency();
        bit e;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            bus_s.En = 1'b1;
            bus_s.IN = (c >= 10);
            sb.push_back(c == 12);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_s.EDGE !== e) begin errors++; $display("FAIL sync_latency cyc %0d: EDGE=%b expected %b", c, bus_s.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        bit in_v[6]  = '{0,1,0,1,1,0};
        bit exp_v[6] = '{0,1,0,1,0,0};
        bit e;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            bus_r.En = 1'b1;
            bus_r.IN = in_v[c];
            sb.push_back(exp_v[c]);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_r.EDGE !== e) begin errors++; $display("FAIL back_to_back cyc %0d: EDGE=%b expected %b", c, bus_r.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_midrun();
        bit e;
        do_reset();
        bus_r.En = 1'b1;
        bus_r.IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Rise while disabled leaves an edge pending.
        bus_r.En = 1'b0;
        bus_r.IN = 1'b1;
        @(posedge clk);
        #1;
        bus_r.En = 1'b1;
        sb.push_back(1'b1);
        #1;
        e = sb.pop_front(); checks++;
        if (bus_r.EDGE !== e) begin errors++; $display("FAIL midrun_pending: EDGE=%b expected %b", bus_r.EDGE, e); end
        rst = 1'b1;
        sb.push_back(1'b0);
        #1;
        e = sb.pop_front(); checks++;
        if (bus_r.EDGE !== e) begin errors++; $display("FAIL midrun_in_reset: EDGE=%b expected %b", bus_r.EDGE, e); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            sb.push_back(1'b0);
            @(negedge clk);
            e = sb.pop_front(); checks++;
            if (bus_r.EDGE !== e) begin errors++; $display("FAIL midrun_after_release cyc %0d: EDGE=%b expected %b", c, bus_r.EDGE, e); end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_r.IN = 1'b0; bus_r.En = 1'b0;
        bus_f.IN = 1'b0; bus_f.En = 1'b0;
        bus_s.IN = 1'b0; bus_s.En = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rise_basic();
        test_fall();
        test_deferred();
        test_lost_pulse();
        test_sync_latency();
        test_back_to_back();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
